branch_resolver: RTL and testbench

Two-stage pipelined branch-condition resolver that consumes the eq/slt/ult flag sets produced by the dual-mode 64-bit comparator and turns them into branch-taken and mispredict decisions. It handles one 64-bit compare (mode=1) or two independent 32-bit lane compares (mode=0) per request. It sits between the comparator and the fetch/redirect logic, with valid/ready handshakes on both sides and saturating statistics counters.

---
 rtl/branch_resolver.sv | 141 ++++++++++++++
 tb/tb_branch_resolver.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_resolver.sv
// Two-stage branch-condition resolver: registers comparator flags in S1, resolves
// taken/mispredict per lane in S2, and keeps saturating handshake statistics.
module branch_resolver #(
    parameter int unsigned TAG_W = 6,
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [2:0]       req_cond,
    input  logic             req_mode,
    input  logic [1:0]       req_pred,
    input  logic [TAG_W-1:0] req_tag,
    input  logic             eqA,
    input  logic             sltA,
    input  logic             ultA,
    input  logic             eqB,
    input  logic             sltB,
    input  logic             ultB,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [1:0]       res_taken,
    output logic [1:0]       res_mispredict,
    output logic             res_illegal,
    output logic             res_mode,
    output logic [TAG_W-1:0] res_tag,
    input  logic             clear_stats,
    output logic [CNT_W-1:0] branch_count,
    output logic [CNT_W-1:0] mispredict_count
);
    localparam int unsigned SUM_W = CNT_W + 1;

    logic             s1_valid;
    logic [2:0]       s1_cond;
    logic             s1_mode;
    logic [1:0]       s1_pred;
    logic [TAG_W-1:0] s1_tag;
    logic [2:0]       s1_flags_a;
    logic [2:0]       s1_flags_b;

    logic             s2_load;
    logic             handshake;
    logic             illegal_c;
    logic [1:0]       taken_c;
    logic [1:0]       mispredict_c;
    logic [1:0]       mis_pop_c;
    logic [SUM_W-1:0] bc_sum_c;
    logic [SUM_W-1:0] mc_sum_c;

    assign s2_load   = !res_valid || res_ready;
    assign req_ready = !s1_valid || s2_load;
    assign handshake = res_valid && res_ready;

    // flags are packed {eq, slt, ult}; cond[0] inverts the selected flag
    function automatic logic lane_taken(input logic [2:0] cond, input logic [2:0] flags);
        logic base;
        case (cond[2:1])
            2'b00:   base = flags[2];
            2'b10:   base = flags[1];
            2'b11:   base = flags[0];
            default: base = 1'b0;
        endcase
        return base ^ cond[0];
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid   <= 1'b0;
            s1_cond    <= '0;
            s1_mode    <= 1'b0;
            s1_pred    <= '0;
            s1_tag     <= '0;
            s1_flags_a <= '0;
            s1_flags_b <= '0;
        end else if (req_ready) begin
            s1_valid <= req_valid;
            if (req_valid) begin
                s1_cond    <= req_cond;
                s1_mode    <= req_mode;
                s1_pred    <= req_pred;
                s1_tag     <= req_tag;
                s1_flags_a <= {eqA, sltA, ultA};
                s1_flags_b <= {eqB, sltB, ultB};
            end
        end
    end

    // Lane B is inactive in unified mode; illegal conditions resolve to not-taken
    always_comb begin
        illegal_c    = (s1_cond[2:1] == 2'b01);
        taken_c      = '0;
        mispredict_c = '0;
        if (!illegal_c) begin
            taken_c[0]      = lane_taken(s1_cond, s1_flags_a);
            mispredict_c[0] = taken_c[0] ^ s1_pred[0];
            if (!s1_mode) begin
                taken_c[1]      = lane_taken(s1_cond, s1_flags_b);
                mispredict_c[1] = taken_c[1] ^ s1_pred[1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            res_valid      <= 1'b0;
            res_taken      <= '0;
            res_mispredict <= '0;
            res_illegal    <= 1'b0;
            res_mode       <= 1'b0;
            res_tag        <= '0;
        end else if (s2_load) begin
            res_valid <= s1_valid;
            if (s1_valid) begin
                res_taken      <= taken_c;
                res_mispredict <= mispredict_c;
                res_illegal    <= illegal_c;
                res_mode       <= s1_mode;
                res_tag        <= s1_tag;
            end
        end
    end

    // One extra sum bit catches overflow so the counters clamp instead of wrapping
    always_comb begin
        mis_pop_c = 2'(res_mispredict[0]) + 2'(res_mispredict[1]);
        bc_sum_c  = {1'b0, branch_count} + SUM_W'(1);
        mc_sum_c  = {1'b0, mispredict_count} + SUM_W'(mis_pop_c);
    end

    always_ff @(posedge clk) begin
        if (!rst_n || clear_stats) begin
            branch_count     <= '0;
            mispredict_count <= '0;
        end else if (handshake) begin
            branch_count     <= bc_sum_c[CNT_W] ? '1 : bc_sum_c[CNT_W-1:0];
            mispredict_count <= mc_sum_c[CNT_W] ? '1 : mc_sum_c[CNT_W-1:0];
        end
    end

endmodule

// File: tb/tb_branch_resolver.sv
// Randomized scoreboard bench for branch_resolver: operand-level reference model,
// decoupled result monitor, saturating counter model on a narrow counter build.
module tb_branch_resolver;
    localparam int unsigned TAG_W = 6;
    localparam int unsigned CNT_W = 4;
    localparam int MAXC = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             req_valid;
    logic             req_ready;
    logic [2:0]       req_cond;
    logic             req_mode;
    logic [1:0]       req_pred;
    logic [TAG_W-1:0] req_tag;
    logic             eqA, sltA, ultA, eqB, sltB, ultB;
    logic             res_valid;
    logic             res_ready;
    logic [1:0]       res_taken;
    logic [1:0]       res_mispredict;
    logic             res_illegal;
    logic             res_mode;
    logic [TAG_W-1:0] res_tag;
    logic             clear_stats;
    logic [CNT_W-1:0] branch_count;
    logic [CNT_W-1:0] mispredict_count;

    branch_resolver #(.TAG_W(TAG_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_cond(req_cond), .req_mode(req_mode), .req_pred(req_pred), .req_tag(req_tag),
        .eqA(eqA), .sltA(sltA), .ultA(ultA), .eqB(eqB), .sltB(sltB), .ultB(ultB),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_taken(res_taken), .res_mispredict(res_mispredict),
        .res_illegal(res_illegal), .res_mode(res_mode), .res_tag(res_tag),
        .clear_stats(clear_stats),
        .branch_count(branch_count), .mispredict_count(mispredict_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]       taken;
        logic [1:0]       mis;
        logic             illegal;
        logic             mode;
        logic [TAG_W-1:0] tag;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          failures = 0;
    int          exp_bc = 0;
    int          exp_mc = 0;
    int unsigned rr_mode = 0;
    int unsigned rr_cnt = 0;
    logic [TAG_W-1:0] tag_ctr = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
        end
    endtask

    // Reference: decide each branch directly from the operand values
    function automatic exp_t model(input logic [2:0] cond, input logic mode, input logic [1:0] pred,
                                   input logic [63:0] a, input logic [63:0] b, input logic [TAG_W-1:0] tag);
        exp_t r;
        longint sa, sb;
        longint unsigned ua, ub;
        logic [31:0] la, lb;
        logic t;
        r = '0;
        r.mode = mode;
        r.tag = tag;
        r.illegal = (cond == 3'b010) || (cond == 3'b011);
        for (int lane = 0; lane < 2; lane++) begin
            if (mode) begin
                sa = $signed(a); sb = $signed(b); ua = a; ub = b;
            end else begin
                la = (lane == 0) ? a[31:0] : a[63:32];
                lb = (lane == 0) ? b[31:0] : b[63:32];
                sa = longint'($signed(la)); sb = longint'($signed(lb));
                ua = 64'(la); ub = 64'(lb);
            end
            case (cond)
                3'b000:  t = (ua == ub);
                3'b001:  t = (ua != ub);
                3'b100:  t = (sa < sb);
                3'b101:  t = (sa >= sb);
                3'b110:  t = (ua < ub);
                3'b111:  t = (ua >= ub);
                default: t = 1'b0;
            endcase
            if (!r.illegal && (lane == 0 || !mode)) begin
                r.taken[lane] = t;
                r.mis[lane]   = t ^ pred[lane];
            end
        end
        return r;
    endfunction

    // Called just after a rising edge; returns just after the accepting edge
    task automatic send(input logic [2:0] cond, input logic mode, input logic [1:0] pred,
                        input logic [63:0] a, input logic [63:0] b);
        int unsigned waits = 0;
        logic accepted = 1'b0;
        req_valid = 1'b1;
        req_cond = cond; req_mode = mode; req_pred = pred; req_tag = tag_ctr;
        if (mode) begin
            eqA = (a == b); sltA = ($signed(a) < $signed(b)); ultA = (a < b);
            {eqB, sltB, ultB} = 3'($urandom);
        end else begin
            eqA = (a[31:0] == b[31:0]); sltA = ($signed(a[31:0]) < $signed(b[31:0])); ultA = (a[31:0] < b[31:0]);
            eqB = (a[63:32] == b[63:32]); sltB = ($signed(a[63:32]) < $signed(b[63:32])); ultB = (a[63:32] < b[63:32]);
        end
        forever begin
            @(negedge clk);
            if (req_ready) begin accepted = 1'b1; break; end
            waits++;
            if (waits > 50) begin
                chk("req_accept_timeout", 64'(req_ready), 64'(1));
                req_valid = 1'b0;
                break;
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        if (accepted) begin
            exp_q.push_back(model(cond, mode, pred, a, b, tag_ctr));
            tag_ctr = tag_ctr + 1'b1;
        end
        req_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    // Consumer readiness: 0 always, 1 random, 2 pattern 1,0,0,1, 3 held low
    initial begin
        res_ready = 1'b0;
        forever begin
            @(posedge clk); #1;
            case (rr_mode)
                0: res_ready = 1'b1;
                1: res_ready = ($urandom_range(0, 3) != 0);
                2: res_ready = ((rr_cnt % 4) == 0) || ((rr_cnt % 4) == 3);
                default: res_ready = 1'b0;
            endcase
            rr_cnt++;
        end
    end

    // Monitor: pops expectations on every result handshake and tracks the counters
    logic        stalled = 1'b0;
    logic [63:0] snap;
    always @(negedge clk) begin
        exp_t e;
        int   pop;
        if (!rst_n) begin
            exp_q.delete();
            exp_bc = 0;
            exp_mc = 0;
            stalled = 1'b0;
        end else begin
            chk("branch_count", 64'(branch_count), 64'(exp_bc));
            chk("mispredict_count", 64'(mispredict_count), 64'(exp_mc));
            chk("req_ready", 64'(req_ready), 64'((exp_q.size() < 2) || res_ready));
            if (stalled)
                chk("stable_while_stalled",
                    64'({res_valid, res_taken, res_mispredict, res_illegal, res_mode, res_tag}), snap);
            pop = 0;
            if (res_valid && res_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_result_tag", 64'(res_tag), 64'hFFFF);
                    pop = int'(res_mispredict[0]) + int'(res_mispredict[1]);
                end else begin
                    e = exp_q.pop_front();
                    chk("res_tag", 64'(res_tag), 64'(e.tag));
                    chk("res_taken", 64'(res_taken), 64'(e.taken));
                    chk("res_mispredict", 64'(res_mispredict), 64'(e.mis));
                    chk("res_illegal", 64'(res_illegal), 64'(e.illegal));
                    chk("res_mode", 64'(res_mode), 64'(e.mode));
                    pop = int'(e.mis[0]) + int'(e.mis[1]);
                end
            end
            if (clear_stats) begin
                exp_bc = 0;
                exp_mc = 0;
            end else if (res_valid && res_ready) begin
                exp_bc = (exp_bc + 1 > MAXC) ? MAXC : exp_bc + 1;
                exp_mc = (exp_mc + pop > MAXC) ? MAXC : exp_mc + pop;
            end
            stalled = res_valid && !res_ready;
            snap = 64'({res_valid, res_taken, res_mispredict, res_illegal, res_mode, res_tag});
        end
    end

    task automatic drain();
        int unsigned n = 0;
        rr_mode = 0;
        while (exp_q.size() != 0 && n < 100) begin @(posedge clk); #1; n++; end
        chk("drain_pending", 64'(exp_q.size()), 64'(0));
    endtask

    initial begin
        logic [63:0] a, b;
        rst_n = 1'b0; req_valid = 1'b0; req_cond = '0; req_mode = 1'b0; req_pred = '0; req_tag = '0;
        {eqA, sltA, ultA, eqB, sltB, ultB} = '0; clear_stats = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_res_valid", 64'(res_valid), 64'(0));
        chk("rst_outputs", 64'({res_taken, res_mispredict, res_illegal, res_mode, res_tag}), 64'(0));
        chk("rst_req_ready", 64'(req_ready), 64'(1));
        @(posedge clk); #1;

        // Unified BLT -1 vs 1, plus exact two-cycle latency
        send(3'b100, 1'b1, 2'b00, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1);
        @(negedge clk); chk("latency_n1_valid", 64'(res_valid), 64'(0));
        @(negedge clk); chk("latency_n2_valid", 64'(res_valid), 64'(1));
        chk("blt_taken", 64'(res_taken), 64'(2'b01));
        @(posedge clk); #1;
        idle(1);
        @(negedge clk);
        chk("blt_branch_count", 64'(branch_count), 64'(1));
        chk("blt_mis_count", 64'(mispredict_count), 64'(1));
        @(posedge clk); #1;

        // Split BGEU, then unified with the same operands; illegal condition
        send(3'b111, 1'b0, 2'b10, {32'd5, 32'd1}, {32'd5, 32'd2});
        send(3'b111, 1'b1, 2'b10, {32'd5, 32'd1}, {32'd5, 32'd2});
        send(3'b010, 1'b0, 2'b11, 64'd3, 64'd3);
        send(3'b011, 1'b1, 2'b01, 64'd3, 64'd4);
        drain();

        // Eight back-to-back requests under a 1,0,0,1 consumer
        tag_ctr = '0;
        rr_mode = 2;
        for (int i = 0; i < 8; i++) send(3'($urandom), 1'($urandom), 2'($urandom), {$urandom, $urandom}, {$urandom, $urandom});
        drain();

        // Saturation: 7 x +2 -> 14, +2 clamps at 15, stays 15; then clear beats a handshake
        clear_stats = 1'b1; idle(1); clear_stats = 1'b0;
        for (int i = 0; i < 9; i++) send(3'b000, 1'b0, 2'b00, 64'd7, 64'd7);
        drain();
        idle(1);
        @(negedge clk); chk("sat_mis_count", 64'(mispredict_count), 64'(MAXC));
        @(posedge clk); #1;
        send(3'b001, 1'b0, 2'b00, 64'd1, 64'd2);
        idle(1);
        clear_stats = 1'b1; idle(1); clear_stats = 1'b0;
        @(negedge clk);
        chk("clear_branch_count", 64'(branch_count), 64'(0));
        chk("clear_mis_count", 64'(mispredict_count), 64'(0));
        @(posedge clk); #1;

        // Randomized traffic with random backpressure and occasional clears
        rr_mode = 1;
        for (int i = 0; i < 300; i++) begin
            a = {$urandom, $urandom};
            case ($urandom_range(0, 3))
                0: b = a;
                1: b = {a[63:32], 32'($urandom)};
                2: b = {32'($urandom), a[31:0]};
                default: b = {$urandom, $urandom};
            endcase
            clear_stats = ($urandom_range(0, 29) == 0);
            send(3'($urandom), 1'($urandom), 2'($urandom), a, b);
            clear_stats = 1'b0;
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
        end
        drain();

        // Reset with two requests in flight drops both
        rr_mode = 3;
        idle(1);
        send(3'b000, 1'b0, 2'b01, 64'd0, 64'd0);
        send(3'b100, 1'b1, 2'b00, 64'd0, 64'd9);
        rst_n = 1'b0;
        idle(1);
        rst_n = 1'b1;
        rr_mode = 0;
        @(negedge clk);
        chk("inflight_rst_valid", 64'(res_valid), 64'(0));
        chk("inflight_rst_ready", 64'(req_ready), 64'(1));
        chk("inflight_rst_counts", 64'({branch_count, mispredict_count}), 64'(0));
        @(posedge clk); #1;
        idle(10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
